// File: rtl/adder_response_checker_if.sv
// Stimulus/response bus between a full-adder test source and adder_response_checker.
// The master side drives the stimulus and the adder response; the slave side is the checker.
interface adder_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             start_in;
  logic             valid_in;
  logic             a_in;
  logic             b_in;
  logic             c_in;
  logic             sum_in;
  logic             carry_in;
  logic             busy_out;
  logic             done_out;
  logic             pass_out;
  logic [CNT_W-1:0] vec_cnt_out;
  logic [CNT_W-1:0] err_cnt_out;
  logic [7:0]       cov_out;
  logic [4:0]       first_err_out;
  logic [CNT_W-1:0] first_err_idx_out;

  modport master (
    output start_in, valid_in, a_in, b_in, c_in, sum_in, carry_in,
    input  busy_out, done_out, pass_out, vec_cnt_out, err_cnt_out, cov_out,
           first_err_out, first_err_idx_out
  );

  modport slave (
    input  start_in, valid_in, a_in, b_in, c_in, sum_in, carry_in,
    output busy_out, done_out, pass_out, vec_cnt_out, err_cnt_out, cov_out,
           first_err_out, first_err_idx_out
  );
endinterface

// File: rtl/adder_response_checker.sv
// Response checker for a 1-bit full adder: compares delayed stimuli with returned sum/carry.
// Define ADDER_CHECK_ERR_LOG_EN to capture the first failing vector and its index.
module adder_response_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int LATENCY     = 0,
  parameter int CNT_W       = 16
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  adder_response_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_VECTORS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_vecCnt;
  logic [CNT_W-1:0] r_errCnt;
  logic [7:0]       r_cov;

  logic             w_start;
  logic             w_enq;
  logic             w_dValid;
  logic [2:0]       w_dAbc;
  logic             w_cmp;
  logic             w_expSum;
  logic             w_expCarry;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_vecInc;
  logic             w_last;

  // start_in is only honoured outside a run; stimuli are only accepted during one.
  assign w_start = bus.start_in && (r_state != S_CHECK);
  assign w_enq   = bus.valid_in && (r_state == S_CHECK);

  generate
    if (LATENCY == 0) begin : g_noDelay
      assign w_dValid = w_enq;
      assign w_dAbc   = {bus.a_in, bus.b_in, bus.c_in};
    end else begin : g_delay
      logic [3:0] r_dly [LATENCY];

      always_ff @(posedge clk_in) begin
        if (!rst_n_in || w_start) begin
          for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= {w_enq, bus.a_in, bus.b_in, bus.c_in};
          for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
      end

      assign w_dValid = r_dly[LATENCY-1][3];
      assign w_dAbc   = r_dly[LATENCY-1][2:0];
    end
  endgenerate

  assign w_cmp      = w_dValid && (r_state == S_CHECK);
  assign w_expSum   = ^w_dAbc;
  assign w_expCarry = (w_dAbc[2] & w_dAbc[1]) | (w_dAbc[2] & w_dAbc[0]) | (w_dAbc[1] & w_dAbc[0]);
  assign w_mismatch = (bus.sum_in != w_expSum) || (bus.carry_in != w_expCarry);
  assign w_vecInc   = r_vecCnt + 1'b1;
  assign w_last     = w_cmp && (w_vecInc == LP_NUM);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_nextState = S_CHECK;
      S_CHECK: if (w_last)  w_nextState = S_DONE;
      S_DONE:  if (w_start) w_nextState = S_CHECK;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || w_start) begin
      r_vecCnt <= '0;
      r_errCnt <= '0;
      r_cov    <= '0;
    end else if (w_cmp) begin
      r_vecCnt        <= w_vecInc;
      r_cov[w_dAbc]   <= 1'b1;
      if (w_mismatch && (r_errCnt != {CNT_W{1'b1}})) r_errCnt <= r_errCnt + 1'b1;
    end
  end

`ifdef ADDER_CHECK_ERR_LOG_EN
  logic [4:0]       r_firstErr;
  logic [CNT_W-1:0] r_firstErrIdx;

  // An error count of zero means this is the first mismatch of the run.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || w_start) begin
      r_firstErr    <= '0;
      r_firstErrIdx <= '0;
    end else if (w_cmp && w_mismatch && (r_errCnt == '0)) begin
      r_firstErr    <= {w_dAbc, bus.sum_in, bus.carry_in};
      r_firstErrIdx <= r_vecCnt;
    end
  end

  assign bus.first_err_out     = r_firstErr;
  assign bus.first_err_idx_out = r_firstErrIdx;
`else
  assign bus.first_err_out     = '0;
  assign bus.first_err_idx_out = '0;
`endif

  assign bus.busy_out    = (r_state == S_CHECK);
  assign bus.done_out    = (r_state == S_DONE);
  assign bus.pass_out    = (r_state == S_DONE) && (r_errCnt == '0) && (r_cov == 8'hFF);
  assign bus.vec_cnt_out = r_vecCnt;
  assign bus.err_cnt_out = r_errCnt;
  assign bus.cov_out     = r_cov;

endmodule

// File: tb/tb_adder_response_checker.sv
// Drives a zero-latency and a two-cycle-latency checker from one stimulus stream and
// compares both against a run-level scoreboard of the vectors sent.
`timescale 1ns/1ps
module tb_adder_response_checker;

  localparam int NV = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic inj;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rstN, startP, vld, sa, sb, sc, inj;
  stim_t q[$];
  int    nAsserts = 0;
  int    nFail    = 0;

  adder_response_checker_if #(.CNT_W(CW)) if0 ();
  adder_response_checker_if #(.CNT_W(CW)) if2 ();

  function automatic logic [1:0] addBits(input logic x, input logic y, input logic z);
    return 2'(x) + 2'(y) + 2'(z);
  endfunction

  // Model adder: the inject flag flips the carry of that vector.
  logic [3:0] pipe1 = '0;
  logic [3:0] pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= {sa, sb, sc, inj};
    pipe2 <= pipe1;
  end

  assign if0.start_in = startP;
  assign if0.valid_in = vld;
  assign if0.a_in     = sa;
  assign if0.b_in     = sb;
  assign if0.c_in     = sc;
  assign if0.sum_in   = addBits(sa, sb, sc) % 2'd2 == 2'd1;
  assign if0.carry_in = (addBits(sa, sb, sc) >= 2'd2) ^ inj;
  assign if2.start_in = startP;
  assign if2.valid_in = vld;
  assign if2.a_in     = sa;
  assign if2.b_in     = sb;
  assign if2.c_in     = sc;
  assign if2.sum_in   = addBits(pipe2[3], pipe2[2], pipe2[1]) % 2'd2 == 2'd1;
  assign if2.carry_in = (addBits(pipe2[3], pipe2[2], pipe2[1]) >= 2'd2) ^ pipe2[0];

  adder_response_checker #(.NUM_VECTORS(NV), .LATENCY(0), .CNT_W(CW)) dut0 (
    .clk_in(clk), .rst_n_in(rstN), .bus(if0));
  adder_response_checker #(.NUM_VECTORS(NV), .LATENCY(2), .CNT_W(CW)) dut2 (
    .clk_in(clk), .rst_n_in(rstN), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkInst(input string tag, input logic busy, input logic done, input logic pass,
                           input int vec, input int err, input int cov, input int fe, input int idx,
                           input int eBusy, input int eDone, input int ePass, input int eVec,
                           input int eErr, input int eCov, input int eFe, input int eIdx);
    checkOutput({tag, ".busy"}, int'(busy), eBusy);
    checkOutput({tag, ".done"}, int'(done), eDone);
    checkOutput({tag, ".pass"}, int'(pass), ePass);
    checkOutput({tag, ".vec"}, vec, eVec);
    checkOutput({tag, ".err"}, err, eErr);
    checkOutput({tag, ".cov"}, cov, eCov);
    checkOutput({tag, ".firstErr"}, fe, eFe);
    checkOutput({tag, ".firstIdx"}, idx, eIdx);
  endtask

  task automatic checkBoth(input string tag, input int eBusy, input int eDone, input int ePass,
                           input int eVec, input int eErr, input int eCov, input int eFe, input int eIdx);
    checkInst({tag, ".lat0"}, if0.busy_out, if0.done_out, if0.pass_out, int'(if0.vec_cnt_out),
              int'(if0.err_cnt_out), int'(if0.cov_out), int'(if0.first_err_out),
              int'(if0.first_err_idx_out), eBusy, eDone, ePass, eVec, eErr, eCov, eFe, eIdx);
    checkInst({tag, ".lat2"}, if2.busy_out, if2.done_out, if2.pass_out, int'(if2.vec_cnt_out),
              int'(if2.err_cnt_out), int'(if2.cov_out), int'(if2.first_err_out),
              int'(if2.first_err_idx_out), eBusy, eDone, ePass, eVec, eErr, eCov, eFe, eIdx);
  endtask

  // Sends the queued vectors as one run, with random idle gaps, then waits for both verdicts.
  task automatic applyStimulus(input int gapMax);
    int waited;
    startP = 1'b1;
    tick();
    startP = 1'b0;
    foreach (q[i]) begin
      vld = 1'b1; sa = q[i].a; sb = q[i].b; sc = q[i].c; inj = q[i].inj;
      tick();
      vld = 1'b0; inj = 1'b0;
      repeat ($urandom_range(0, gapMax)) tick();
    end
    vld = 1'b0;
    waited = 0;
    while (!(if0.done_out && if2.done_out) && waited < 60) begin
      tick();
      waited++;
    end
    checkOutput("doneTimeout", int'(if0.done_out && if2.done_out), 1);
  endtask

  // Scoreboard: verdict derived from the list of vectors sent in the run.
  task automatic expectRun(input string tag);
    int n, err, cov, fe, idx, pass;
    logic [2:0] abc;
    logic [1:0] r;
    n = (q.size() < NV) ? q.size() : NV;
    err = 0; cov = 0; fe = 0; idx = 0;
    for (int i = 0; i < n; i++) begin
      abc = {q[i].a, q[i].b, q[i].c};
      cov = cov | (1 << abc);
      if (q[i].inj) begin
        r = addBits(q[i].a, q[i].b, q[i].c);
        if (err == 0) begin
          fe  = {abc, r[0], ~r[1]};
          idx = i;
        end
        err++;
      end
    end
    pass = (err == 0 && cov == 255) ? 1 : 0;
`ifndef ADDER_CHECK_ERR_LOG_EN
    fe = 0; idx = 0;
`endif
    checkBoth(tag, 0, 1, pass, n, err, cov, fe, idx);
  endtask

  function automatic stim_t mk(input int abc, input logic injErr);
    stim_t s;
    s.a = abc[2]; s.b = abc[1]; s.c = abc[0]; s.inj = injErr;
    return s;
  endfunction

  initial begin
    rstN = 1'b0; startP = 1'b0; vld = 1'b0; sa = 1'b0; sb = 1'b0; sc = 1'b0; inj = 1'b0;
    repeat (2) tick();
    checkBoth("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rstN = 1'b1;
    tick();

    $display("[TB] exhaustive combos, back to back");
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(i, 1'b0));
    applyStimulus(0);
    expectRun("exhaustive");

    $display("[TB] exhaustive combos with gaps");
    q.shuffle();
    applyStimulus(3);
    expectRun("gaps");

    $display("[TB] carry forced low on 011");
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(i, i == 3));
    applyStimulus(1);
    expectRun("fault011");

    $display("[TB] vector 000 repeated");
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(0, 1'b0));
    applyStimulus(1);
    expectRun("repeat000");

    for (int run = 0; run < 6; run++) begin
      $display("[TB] random run %0d", run);
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 3) == 0));
      applyStimulus(2);
      expectRun($sformatf("random%0d", run));
    end

    $display("[TB] reset in the middle of a run");
    startP = 1'b1;
    tick();
    startP = 1'b0;
    checkBoth("runStart", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; sa = 1'b1; sb = 1'b1; sc = 1'b1; inj = 1'b0;
      tick();
    end
    vld = 1'b0;
    repeat (3) tick();
    checkBoth("midRun", 1, 0, 0, 4, 0, 8'h80, 0, 0);
    startP = 1'b1;
    tick();
    startP = 1'b0;
    tick();
    checkBoth("startWhileBusy", 1, 0, 0, 4, 0, 8'h80, 0, 0);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkBoth("midReset", 0, 0, 0, 0, 0, 0, 0, 0);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(mk(7 - i, 1'b0));
    applyStimulus(1);
    expectRun("afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
